// File: rtl/pio_cmd_pkg.sv
// pio_cmd_pkg: opcode and state encodings, instruction field positions, flag indices
package pio_cmd_pkg;
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_WRITE   = 3'd1,
        OP_RUN     = 3'd2,
        OP_ENG_RST = 3'd3,
        OP_CLEAR   = 3'd4
    } opcode_t;
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_MEM_WR, S_ENG_START, S_ENG_WAIT, S_ENG_RST, S_DONE
    } state_t;
    localparam int OPC_LSB  = 0;
    localparam int ADDR_LSB = 3;
    localparam int DATA_LSB = 20;
    localparam int RSV_BIT  = 28;
    localparam int FLG_DONE = 0;
    localparam int FLG_BUSY = 1;
    localparam int FLG_ERR  = 2;
    localparam int FLG_OVR  = 3;
    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_CLEAR);
    endfunction
endpackage

// File: rtl/pio_handshake_sync.sv
// pio_handshake_sync: 2-flop synchronizer and registered rising-edge detector for pio_enable
module pio_handshake_sync (
    input  logic clk,
    input  logic reset,
    input  logic pio_enable,
    output logic en_rise
);
    logic [2:0] sync;
    always_ff @(posedge clk)
        if (reset) begin
            sync    <= '0;
            en_rise <= 1'b0;
        end else begin
            sync    <= {sync[1:0], pio_enable};
            en_rise <= sync[1] & ~sync[2];
        end
endmodule

// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer: HPS PIO command capture/decode/sequencing; ENG_WAIT watchdog enabled by PIO_TIMEOUT_EN
module pio_cmd_sequencer
    import pio_cmd_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [28:0]       pio_instruct,
    input  logic              pio_enable,
    output logic [3:0]        pio_flags,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    output logic              eng_start,
    output logic [2:0]        eng_mode,
    input  logic              eng_done,
    output logic              eng_rst
);
    localparam int RCW = $clog2(RST_CYCLES + 1);
    state_t         state, nxt;
    logic [28:0]    word;
    logic [2:0]     opc;
    logic           bad, is_clr, en_rise, tmo, rst_last;
    logic [RCW-1:0] rst_cnt;
    pio_handshake_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .pio_enable(pio_enable),
        .en_rise   (en_rise)
    );
    assign opc      = word[OPC_LSB +: 3];
    assign bad      = word[RSV_BIT] | ~op_legal(opc);
    assign is_clr   = ~bad && opc == OP_CLEAR;
    assign rst_last = rst_cnt == RCW'(RST_CYCLES - 1);
`ifdef PIO_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    logic [TCW-1:0] tmo_cnt;
    always_ff @(posedge clk)
        tmo_cnt <= (reset || state != S_ENG_WAIT) ? '0 : tmo_cnt + 1'b1;
    assign tmo = tmo_cnt == TCW'(TIMEOUT_CYC - 1);
`else
    logic timeout_unused;
    assign timeout_unused = TIMEOUT_CYC[0];
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk)
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:      nxt = en_rise ? S_DECODE : S_IDLE;
            S_DECODE:    nxt = bad              ? S_DONE      :
                               opc == OP_WRITE  ? S_MEM_WR    :
                               opc == OP_RUN    ? S_ENG_START :
                               opc == OP_ENG_RST? S_ENG_RST   : S_DONE;
            S_MEM_WR:    nxt = mem_ready ? S_DONE : S_MEM_WR;
            S_ENG_START: nxt = S_ENG_WAIT;
            S_ENG_WAIT:  nxt = eng_done ? S_DONE : tmo ? S_ENG_RST : S_ENG_WAIT;
            S_ENG_RST:   nxt = rst_last ? S_DONE : S_ENG_RST;
            default:     nxt = S_IDLE;
        endcase
    end
    always_comb begin
        mem_we    = state == S_MEM_WR;
        eng_start = state == S_ENG_START;
        eng_rst   = state == S_ENG_RST;
        eng_mode  = (state == S_ENG_START || state == S_ENG_WAIT) ? word[DATA_LSB +: 3] : 3'd0;
    end
    assign mem_addr  = word[ADDR_LSB +: ADDR_W];
    assign mem_wdata = word[DATA_LSB +: DATA_W];
    // A rise outside IDLE is a dropped command: only the sticky overrun flag records it
    always_ff @(posedge clk)
        if (reset) begin
            word      <= '0;
            rst_cnt   <= '0;
            pio_flags <= '0;
        end else begin
            if (state == S_IDLE && en_rise) begin
                word                <= pio_instruct;
                pio_flags           <= '0;
                pio_flags[FLG_BUSY] <= 1'b1;
            end else if (en_rise) pio_flags[FLG_OVR] <= 1'b1;
            if (state == S_DECODE && bad) pio_flags[FLG_ERR] <= 1'b1;
            if (state == S_ENG_WAIT && tmo && !eng_done) pio_flags[FLG_ERR] <= 1'b1;
            if (state == S_DONE) begin
                pio_flags[FLG_BUSY] <= 1'b0;
                pio_flags[FLG_DONE] <= ~is_clr;
            end
            rst_cnt <= state == S_ENG_RST ? rst_cnt + 1'b1 : '0;
        end
endmodule
